// File: rtl/chop_seq_mult_18x18_pkg.sv
// Shared constants, FSM encoding and chop-pair schedule for the sequential
// 18x18 multiplier built around a single 9x9 core.
package chop_seq_mult_18x18_pkg;

    localparam int CHOP      = 9;
    localparam int NUM_PAIRS = 4;
    localparam int A_WIDTH   = 2 * CHOP;
    localparam int B_WIDTH   = 2 * CHOP;
    localparam int P_WIDTH   = 2 * CHOP;
    localparam int C_WIDTH   = A_WIDTH + B_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Pair schedule: p0=A0*B0, p1=A1*B0, p2=A0*B1, p3=A1*B1
    function automatic logic pair_a_idx(input logic [1:0] idx);
        return idx[0];
    endfunction

    function automatic logic pair_b_idx(input logic [1:0] idx);
        return idx[1];
    endfunction

    function automatic int unsigned pair_shift(input logic [1:0] idx);
        case (idx)
            2'd0:    return 0;
            2'd1:    return CHOP;
            2'd2:    return CHOP;
            default: return 2 * CHOP;
        endcase
    endfunction

endpackage

// File: rtl/chop_seq_mult_18x18_core.sv
// Registered 9x9 multiplier with per-operand sign flags and 1-cycle latency.
// Half mode splits the core into two unsigned 4x4 products.
module chop_mult_9x9_core
    import chop_seq_mult_18x18_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CHOP-1:0]      a,
    input  logic [CHOP-1:0]      b,
    input  logic                 a_sign,
    input  logic                 b_sign,
    input  logic                 half_mode,
    output logic [P_WIDTH-1:0]   p
);

    logic signed [CHOP:0]        a_ext;
    logic signed [CHOP:0]        b_ext;
    logic signed [2*CHOP+1:0]    full_prod;
    logic [7:0]                  lo_prod;
    logic [7:0]                  hi_prod;
    logic [P_WIDTH-1:0]          p_d;
    logic [P_WIDTH-1:0]          p_q;

    always_comb begin
        a_ext     = {a[CHOP-1] & a_sign, a};
        b_ext     = {b[CHOP-1] & b_sign, b};
        full_prod = a_ext * b_ext;
        lo_prod   = a[3:0] * b[3:0];
        hi_prod   = a[7:4] * b[7:4];
        if (half_mode) begin
            p_d = {2'b00, hi_prod, lo_prod};
        end else begin
            p_d = full_prod[P_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/chop_seq_mult_18x18.sv
// Sequential 18x18 multiplier: four chop products through one 9x9 core,
// extended, shifted and accumulated into a 36-bit result.
module chop_seq_mult_18x18
    import chop_seq_mult_18x18_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   A,
    input  logic [B_WIDTH-1:0]   B,
    input  logic                 A_sign,
    input  logic                 B_sign,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [C_WIDTH-1:0]   C,
    output logic                 busy
);

    state_t               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [A_WIDTH-1:0]   a_q, a_d;
    logic [B_WIDTH-1:0]   b_q, b_d;
    logic                 a_sign_q, a_sign_d;
    logic                 b_sign_q, b_sign_d;
    logic [C_WIDTH-1:0]   acc_q, acc_d;
    logic [C_WIDTH-1:0]   c_q, c_d;

    logic [1:0]           issue_idx;
    logic [1:0]           acc_idx;
    logic [CHOP-1:0]      core_a;
    logic [CHOP-1:0]      core_b;
    logic                 core_a_sign;
    logic                 core_b_sign;
    logic [P_WIDTH-1:0]   core_p;
    logic                 ext_signed;
    logic [C_WIDTH-1:0]   prod_ext;
    logic [C_WIDTH-1:0]   prod_shifted;
    logic [C_WIDTH-1:0]   acc_sum;
    logic                 accept;

    assign accept = (state_q == ST_IDLE) && in_valid;

    // Chop muxing: cnt selects the pair issued now; cnt-1 the pair whose
    // product is emerging from the core this cycle.
    always_comb begin
        issue_idx   = cnt_q[1:0];
        acc_idx     = 2'(cnt_q - 3'd1);
        core_a      = pair_a_idx(issue_idx) ? a_q[A_WIDTH-1:CHOP] : a_q[CHOP-1:0];
        core_b      = pair_b_idx(issue_idx) ? b_q[B_WIDTH-1:CHOP] : b_q[CHOP-1:0];
        core_a_sign = pair_a_idx(issue_idx) & a_sign_q;
        core_b_sign = pair_b_idx(issue_idx) & b_sign_q;
    end

    chop_mult_9x9_core u_core (
        .clk       (clk),
        .reset     (reset),
        .a         (core_a),
        .b         (core_b),
        .a_sign    (core_a_sign),
        .b_sign    (core_b_sign),
        .half_mode (1'b0),
        .p         (core_p)
    );

    always_comb begin
        ext_signed   = (pair_a_idx(acc_idx) & a_sign_q) | (pair_b_idx(acc_idx) & b_sign_q);
        prod_ext     = ext_signed ? {{(C_WIDTH-P_WIDTH){core_p[P_WIDTH-1]}}, core_p}
                                  : {{(C_WIDTH-P_WIDTH){1'b0}}, core_p};
        prod_shifted = prod_ext << pair_shift(acc_idx);
        acc_sum      = acc_q + prod_shifted;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            acc_q    <= '0;
            c_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            a_sign_q <= a_sign_d;
            b_sign_q <= b_sign_d;
            acc_q    <= acc_d;
            c_q      <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)         state_d = ST_RUN;
            ST_RUN:  if (cnt_q == 3'd4)    state_d = ST_OUT;
            ST_OUT:  if (out_ready)        state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        a_sign_d = a_sign_q;
        b_sign_d = b_sign_q;
        acc_d    = acc_q;
        c_d      = c_q;
        if (accept) begin
            a_d      = A;
            b_d      = B;
            a_sign_d = A_sign;
            b_sign_d = B_sign;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (state_q == ST_RUN) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q != 3'd0) begin
                acc_d = acc_sum;
            end
            if (cnt_q == 3'd4) begin
                c_d = acc_sum;
            end
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_OUT);
        busy      = (state_q == ST_RUN) || (state_q == ST_OUT);
        C         = c_q;
    end

endmodule

// File: tb/tb_chop_seq_mult_18x18.sv
// Randomized self-checking bench for chop_seq_mult_18x18 against a plain
// arithmetic product model.
module tb_chop_seq_mult_18x18;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] A;
    logic [17:0] B;
    logic        A_sign;
    logic        B_sign;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] C;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    chop_seq_mult_18x18 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .A_sign    (A_sign),
        .B_sign    (B_sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] model(input logic [17:0] a, input logic [17:0] b,
                                          input logic as, input logic bs);
        longint av;
        longint bv;
        longint p;
        av = as ? longint'($signed(a)) : longint'(a);
        bv = bs ? longint'($signed(b)) : longint'(b);
        p  = av * bv;
        return p[35:0];
    endfunction

    // Offer one operand pair, wait for the result, check it, then drain
    // after hold_cycles of backpressure.
    task automatic do_op(input logic [17:0] a, input logic [17:0] b,
                         input logic as, input logic bs,
                         input bit scramble, input int hold_cycles);
        logic [35:0] exp;
        int n;
        exp = model(a, b, as, bs);
        @(negedge clk);
        A = a; B = b; A_sign = as; B_sign = bs; in_valid = 1'b1;
        check("in_ready_idle", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_run", busy, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            if (scramble) begin
                A = 18'($urandom); B = 18'($urandom);
                A_sign = 1'($urandom); B_sign = 1'($urandom);
                out_ready = 1'($urandom);
            end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("latency", n, 5);
        check("result", C, exp);
        check("in_ready_out", in_ready, 1'b0);
        for (int i = 0; i < hold_cycles; i++) begin
            if (i == 3) begin
                in_valid = 1'b1; A = 18'h00123; B = 18'h00456; A_sign = 1'b0; B_sign = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", out_valid, 1'b1);
            check("hold_c", C, exp);
            check("hold_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_in_ready", in_ready, 1'b1);
        check("drain_valid", out_valid, 1'b0);
        $display("op A=%05h(%0d) B=%05h(%0d) C=%09h exp=%09h", a, as, b, bs, C, exp);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; A_sign = 1'b0; B_sign = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_c", C, 36'h0);

        do_op(18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b0, 0);
        do_op(18'h3FFFF, 18'h3FFFF, 1'b1, 1'b1, 1'b0, 0);
        do_op(18'h20000, 18'h3FFFF, 1'b1, 1'b0, 1'b0, 0);
        do_op(18'h20000, 18'h20000, 1'b1, 1'b1, 1'b0, 0);
        do_op(18'h12345, 18'h2ABCD, 1'b0, 1'b1, 1'b0, 10);
        do_op(18'd7, 18'd9, 1'b0, 1'b0, 1'b1, 0);
        check("scramble_63", C, 36'd63);

        // Abort mid-run: reset after cnt has reached 2.
        @(negedge clk);
        A = 18'h3FFFF; B = 18'h3FFFF; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_valid", out_valid, 1'b0);
        check("abort_c", C, 36'h0);
        check("abort_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("abort_no_result", out_valid, 1'b0);
        end
        do_op(18'd3, 18'd5, 1'b0, 1'b0, 1'b0, 0);
        check("after_abort_15", C, 36'd15);

        for (int t = 0; t < 40; t++) begin
            do_op(18'($urandom), 18'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
